// File: rtl/uart_hd_xcvr.sv
// Half-duplex UART transceiver: one shared FSM arbitrates a single serial line
// between transmit and receive, with parity, turnaround guard and RX error flags.
module uart_hd_xcvr #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned TURNAROUND   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        parity_mode,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              line_tx,
  output logic              line_oe,
  input  logic              line_rx
);

  localparam int unsigned GUARD_CYC = (TURNAROUND * CLKS_PER_BIT > 0) ? TURNAROUND * CLKS_PER_BIT : 1;
  localparam int unsigned CNT_MAX   = (GUARD_CYC > CLKS_PER_BIT) ? GUARD_CYC : CLKS_PER_BIT;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);
  localparam int unsigned IDX_W     = $clog2(DATA_W);
  localparam int unsigned HALF      = CLKS_PER_BIT / 2;

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP,
    RX_START, RX_DATA, RX_PAR, RX_STOP, GUARD
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic                sync1, rxs, rxs_q;
  logic [DATA_W-1:0]   tx_shift, rx_shift;
  logic                tx_par, rx_par, par_en, par_odd, dir_tx;
  logic                line_tx_d, line_oe_d, busy_d, done_d, valid_d;

  logic rx_fall, bit_tick, half_tick, guard_end, last_data, last_stop, accept, rx_begin;
  assign rx_fall   = rxs_q & ~rxs;
  assign bit_tick  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign half_tick = (cnt == CNT_W'(HALF - 1));
  assign guard_end = (cnt == CNT_W'(GUARD_CYC - 1));
  assign last_data = (bit_idx == IDX_W'(DATA_W - 1));
  assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));
  assign rx_begin  = (state == IDLE) && rx_fall;
  assign accept    = (state == IDLE) && tx_start && !rx_fall;

  // Line input synchroniser plus edge-detect stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync1 <= line_rx;
      rxs   <= sync1;
      rxs_q <= rxs;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; receive wins a same-cycle tie with tx_start
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (rx_fall) state_nx = RX_START;
                else if (tx_start) state_nx = TX_START;
      TX_START: if (bit_tick) state_nx = TX_DATA;
      TX_DATA:  if (bit_tick && last_data) state_nx = par_en ? TX_PAR : TX_STOP;
      TX_PAR:   if (bit_tick) state_nx = TX_STOP;
      TX_STOP:  if (bit_tick && last_stop) state_nx = GUARD;
      RX_START: if (half_tick) state_nx = rxs ? IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && last_data) state_nx = par_en ? RX_PAR : RX_STOP;
      RX_PAR:   if (bit_tick) state_nx = RX_STOP;
      RX_STOP:  if (bit_tick) state_nx = GUARD;
      GUARD:    if (guard_end) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the current state
  always_comb begin
    line_tx_d = 1'b1;
    line_oe_d = 1'b0;
    busy_d    = (state != IDLE);
    done_d    = 1'b0;
    valid_d   = 1'b0;
    case (state)
      TX_START: begin line_tx_d = 1'b0;        line_oe_d = 1'b1; end
      TX_DATA:  begin line_tx_d = tx_shift[0]; line_oe_d = 1'b1; end
      TX_PAR:   begin line_tx_d = tx_par;      line_oe_d = 1'b1; end
      TX_STOP:  begin line_tx_d = 1'b1;        line_oe_d = 1'b1; end
      RX_STOP:  valid_d = bit_tick;
      GUARD:    done_d  = dir_tx && (cnt == '0);
      default:  ;
    endcase
  end

  // Output registers; async reset drops the line driver immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_tx  <= 1'b1;
      line_oe  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      line_tx  <= line_tx_d;
      line_oe  <= line_oe_d;
      tx_busy  <= busy_d;
      tx_done  <= done_d;
      rx_valid <= valid_d;
    end
  end

  // Bit timing counter and bit index, restarted on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state_nx != state || state == IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state != GUARD && bit_tick) begin
      cnt     <= '0;
      bit_idx <= bit_idx + IDX_W'(1);
    end else begin
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // Frame datapath: capture at frame start, shift per bit, publish RX result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift      <= '0;
      tx_par        <= 1'b0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      par_en        <= 1'b0;
      par_odd       <= 1'b0;
      dir_tx        <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      if (accept || rx_begin) begin
        par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_odd <= (parity_mode == 2'b10);
        dir_tx  <= accept;
      end
      if (accept) begin
        tx_shift <= tx_data;
        tx_par   <= (^tx_data) ^ (parity_mode == 2'b10);
      end
      if (state == TX_DATA && bit_tick) tx_shift <= tx_shift >> 1;
      if (state == RX_DATA && bit_tick) rx_shift <= {rxs, rx_shift[DATA_W-1:1]};
      if (state == RX_PAR && bit_tick)  rx_par   <= rxs;
      if (state == RX_STOP && bit_tick) begin
        rx_data       <= rx_shift;
        rx_parity_err <= par_en & ((^rx_shift) ^ rx_par ^ par_odd);
        rx_frame_err  <= ~rxs;
      end
    end
  end

endmodule

// File: tb/tb_uart_hd_xcvr.sv
// Scoreboard bench for uart_hd_xcvr: expected TX frames and RX results are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_uart_hd_xcvr;

  localparam int unsigned C  = 16;
  localparam int unsigned TG = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_done, rx_valid, rx_parity_err, rx_frame_err;
  logic [7:0] rx_data;
  logic       line_tx, line_oe;
  logic       line_rx = 1'b1;

  uart_hd_xcvr #(.DATA_W(8), .CLKS_PER_BIT(C), .STOP_BITS(1), .TURNAROUND(TG)) dut (
    .clk(clk), .rst(rst), .parity_mode(parity_mode), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .line_tx(line_tx), .line_oe(line_oe), .line_rx(line_rx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] bits; int n; } txf_t;
  typedef struct { logic [7:0] data; logic perr; logic ferr; } rxf_t;

  txf_t txq[$];
  rxf_t rxq[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  logic oe_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Reference line image of a transmit frame, start bit at index 0
  function automatic txf_t tx_model(input logic [7:0] d, input logic [1:0] m);
    txf_t f;
    int   i;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) f.bits[1+j] = d[j];
    i = 9;
    if (m == 2'b01) begin f.bits[9] = ^d;  i = 10; end
    if (m == 2'b10) begin f.bits[9] = ~^d; i = 10; end
    f.bits[i] = 1'b1;
    f.n = i + 1;
    return f;
  endfunction

  // Activity watch: tx_done pulses and any driver enable
  initial forever begin
    @(negedge clk);
    if (tx_done) done_cnt++;
    if (line_oe) oe_seen = 1'b1;
  end

  // TX monitor: decode line_tx at each bit midpoint once line_oe rises
  initial begin
    int          mcnt;
    logic        act;
    logic        oe_prev;
    logic        oe_ok;
    logic [15:0] obs;
    txf_t        e;
    act = 1'b0; oe_prev = 1'b0; mcnt = 0; oe_ok = 1'b1; obs = '1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        act = 1'b0;
        oe_prev = 1'b0;
      end else begin
        if (!act && line_oe && !oe_prev) begin
          act = 1'b1; mcnt = 0; obs = '1; oe_ok = 1'b1;
        end
        if (act) begin
          if (mcnt % C == C / 2) begin
            obs[mcnt / C] = line_tx;
            oe_ok = oe_ok & line_oe;
            if (txq.size() == 0) begin
              check("tx_spurious_frame", 32'(txq.size()), 32'd1);
              act = 1'b0;
            end else if (mcnt / C == txq[0].n - 1) begin
              e = txq.pop_front();
              check("tx_frame_bits", 32'(obs), 32'(e.bits));
              check("tx_oe_held", 32'(oe_ok), 32'd1);
              act = 1'b0;
            end
          end
          mcnt++;
        end
        oe_prev = line_oe;
      end
    end
  end

  // RX monitor: every rx_valid pops one expected result
  initial forever begin
    rxf_t e;
    @(negedge clk);
    if (rst && rx_valid) begin
      if (rxq.size() == 0) check("rx_spurious_valid", 32'(rxq.size()), 32'd1);
      else begin
        e = rxq.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
        check("rx_frame_err", 32'(rx_frame_err), 32'(e.ferr));
      end
    end
  end

  task automatic start_tx(input logic [7:0] d, input logic [1:0] m);
    parity_mode = m;
    tx_data     = d;
    tx_start    = 1'b1;
    txq.push_back(tx_model(d, m));
    @(negedge clk);
    tx_start    = 1'b0;
    tx_data     = ~d;
    parity_mode = ~m;
  endtask

  task automatic wait_done(output int dly);
    dly = 0;
    while (!tx_done && dly < 1000) begin @(negedge clk); dly++; end
  endtask

  task automatic wait_idle(output int dly);
    dly = 0;
    while (tx_busy && dly < 1000) begin @(negedge clk); dly++; end
  endtask

  // Drive one frame on line_rx, one bit per C clocks
  task automatic drive_rx(input logic [7:0] d, input logic [1:0] m, input logic flip, input logic stopv);
    logic pen, par;
    rxf_t e;
    pen = (m == 2'b01) || (m == 2'b10);
    par = (^d) ^ (m == 2'b10) ^ flip;
    e.data = d; e.perr = pen & flip; e.ferr = ~stopv;
    rxq.push_back(e);
    parity_mode = m;
    line_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line_rx = d[i];
      repeat (C) @(negedge clk);
    end
    if (pen) begin
      line_rx = par;
      repeat (C) @(negedge clk);
    end
    line_rx = stopv;
    repeat (C) @(negedge clk);
    line_rx = 1'b1;
  endtask

  task automatic rx_settle(input string tag);
    int n;
    int dly;
    n = 0;
    while (rxq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check(tag, 32'(rxq.size()), 32'd0);
    wait_idle(dly);
    check("rx_busy_release", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dly;
    int d0;

    repeat (3) @(negedge clk);
    check("rst_line_tx", 32'(line_tx), 32'd1);
    check("rst_line_oe", 32'(line_oe), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_perr", 32'(rx_parity_err), 32'd0);
    check("rst_rx_ferr", 32'(rx_frame_err), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Basic transmit, no parity
    d0 = done_cnt;
    start_tx(8'hC3, 2'b00);
    check("t1_oe_at_accept", 32'(line_oe), 32'd0);
    @(negedge clk);
    check("t1_oe_rise", 32'(line_oe), 32'd1);
    check("t1_start_bit", 32'(line_tx), 32'd0);
    check("t1_busy_rise", 32'(tx_busy), 32'd1);
    wait_done(dly);
    check("t1_done_latency", 32'(dly + 1), 32'd161);
    check("t1_oe_fall", 32'(line_oe), 32'd0);
    wait_idle(dly);
    check("t1_guard_len", 32'(dly), 32'(TG * C));
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Transmit with even then odd parity
    start_tx(8'hC1, 2'b01);
    wait_done(dly);
    check("t2_even_latency", 32'(dly), 32'd177);
    wait_idle(dly);
    start_tx(8'hC1, 2'b10);
    wait_done(dly);
    check("t2_odd_latency", 32'(dly), 32'd177);
    wait_idle(dly);

    // Receive with correct and flipped odd parity
    drive_rx(8'h5A, 2'b10, 1'b0, 1'b1);
    rx_settle("t3_rx_good");
    drive_rx(8'h5A, 2'b10, 1'b1, 1'b1);
    rx_settle("t3_rx_bad_parity");

    // Frame error, then a false start glitch
    drive_rx(8'h3C, 2'b00, 1'b0, 1'b0);
    rx_settle("t4_rx_frame_err");
    repeat (5) @(negedge clk);
    line_rx = 1'b0;
    repeat (4) @(negedge clk);
    line_rx = 1'b1;
    @(negedge clk);
    check("t4_glitch_busy", 32'(tx_busy), 32'd1);
    repeat (10) @(negedge clk);
    check("t4_glitch_release", 32'(tx_busy), 32'd0);

    // Collision: tx_start lands on the same cycle as the rxs falling edge
    repeat (5) @(negedge clk);
    oe_seen = 1'b0;
    fork
      drive_rx(8'h96, 2'b00, 1'b0, 1'b1);
      begin
        repeat (2) @(negedge clk);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    rx_settle("t5_collision_rx");
    repeat (20) @(negedge clk);
    check("t5_collision_no_oe", 32'(oe_seen), 32'd0);

    // Guard: tx_start and line toggles during turnaround are ignored
    start_tx(8'h0F, 2'b00);
    wait_done(dly);
    d0 = done_cnt;
    oe_seen = 1'b0;
    repeat (3) @(negedge clk);
    line_rx = 1'b0;
    repeat (3) @(negedge clk);
    line_rx = 1'b1;
    tx_data = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (2) @(negedge clk);
    line_rx = 1'b0;
    repeat (3) @(negedge clk);
    line_rx = 1'b1;
    wait_idle(dly);
    check("t5_guard_len", 32'(dly + 12), 32'(TG * C));
    repeat (40) @(negedge clk);
    check("t5_guard_no_oe", 32'(oe_seen), 32'd0);
    check("t5_guard_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_guard_idle", 32'(tx_busy), 32'd0);

    // Reset in the middle of the data bits
    start_tx(8'h00, 2'b00);
    repeat (40) @(negedge clk);
    check("t6_pre_reset_data", 32'(line_tx), 32'd0);
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    check("t6_async_line_tx", 32'(line_tx), 32'd1);
    check("t6_async_line_oe", 32'(line_oe), 32'd0);
    check("t6_async_busy", 32'(tx_busy), 32'd0);
    txq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    start_tx(8'hA7, 2'b10);
    wait_done(dly);
    check("t6_post_reset_latency", 32'(dly), 32'd177);
    wait_idle(dly);

    repeat (5) @(negedge clk);
    check("end_txq_empty", 32'(txq.size()), 32'd0);
    check("end_rxq_empty", 32'(rxq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_hd_xcvr.md
# uart_hd_xcvr

Parametrised half-duplex UART transceiver; next generation of the team's fixed 8-bit half-duplex UART. Adds configurable data width, baud divider, and stop-bit count, plus runtime parity and direction arbitration. Adds a turnaround guard and receive error flags. Sits between a byte/word producer-consumer and a single shared serial line driven through an external tri-state buffer (`line_tx` / `line_oe` / `line_rx`).

## Interface

**Parameters**

- `DATA_W`, default 8: data bits per frame. Legal range 5..9.
- `CLKS_PER_BIT`, default 16: clk cycles per bit. Must be even and ≥ 4.
- `STOP_BITS`, default 1: transmitted stop bits. Legal values 1 or 2.
- `TURNAROUND`, default 2: guard time in bit-times after any frame before the next transmit is accepted.

**Ports**

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none. Sampled at frame start.
- `tx_start` in 1: request to transmit `tx_data`. Honoured only while `tx_busy` = 0.
- `tx_data` in DATA_W: word to send. Captured on the accepting edge.
- `tx_busy` out 1: high while transmitting, receiving, or in guard time.
- `tx_done` out 1: one-cycle pulse when the last stop bit has finished.
- `rx_data` out DATA_W: last received word. Held until the next `rx_valid`.
- `rx_valid` out 1: one-cycle pulse per received frame.
- `rx_parity_err` out 1: parity status of the last frame. Valid with `rx_valid`, held until the next one.
- `rx_frame_err` out 1: first stop bit sampled low. Valid with `rx_valid`, held until the next one.
- `line_tx` out 1: serial output data; idles at 1.
- `line_oe` out 1: output enable for the line driver; high only during a transmit frame.
- `line_rx` in 1: serial line input (asynchronous).

## Operation

**Reset.** While `rst` = 0:
- `line_tx` = 1, `line_oe` = 0.
- `tx_busy`, `tx_done`, `rx_valid`, `rx_parity_err`, `rx_frame_err` = 0.
- `rx_data` = 0.
- Both `line_rx` synchroniser flops = 1.
- FSM in IDLE.

Reset mid-frame aborts the frame immediately, with no `tx_done` or `rx_valid`.

**FSM states:** IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, RX_START, RX_DATA, RX_PAR, RX_STOP, GUARD. One shared FSM means the block is never transmitting and receiving at the same time.

**Receive path**
- `line_rx` passes through a 2-flop synchroniser, giving `rxs`.
- IDLE → RX_START on a falling edge of `rxs`, provided `tx_start` is not also being accepted.
- In RX_START, wait CLKS_PER_BIT/2 cycles, then re-sample. If `rxs` = 1, it was a false start: return to IDLE with no outputs. Otherwise go to RX_DATA.
- RX_DATA: sample every CLKS_PER_BIT cycles, DATA_W bits, LSB first.
- RX_PAR: present only if parity is enabled; one sample.
- RX_STOP: one sample. On the cycle after this sample:
  - `rx_valid` pulses.
  - `rx_data`, `rx_parity_err`, and `rx_frame_err` update.
  - A frame error still produces `rx_valid`.
  - Go to GUARD.
- A second stop bit is never checked on receive.

**Transmit path**
- IDLE with `tx_start` = 1 and no `rxs` falling edge: capture `tx_data`, go to TX_START.
- Send the start bit (0), then DATA_W data bits LSB first.
- Parity bit if enabled: even mode makes the total count of ones in data + parity even; odd mode makes it odd.
- Then STOP_BITS stop bits (1).
- Then drop `line_oe`, pulse `tx_done`, and go to GUARD.

**Guard.** GUARD lasts TURNAROUND×CLKS_PER_BIT cycles and then returns to IDLE. During GUARD:
- `tx_busy` = 1.
- `tx_start` is ignored.
- `rxs` edges are ignored. This suppresses echo of our own transmission.

**Simultaneous events**
- A `tx_start` and an `rxs` falling edge in the same IDLE cycle: receive wins and `tx_start` is dropped. The requester must re-issue once `tx_busy` falls.
- `tx_start` while `tx_busy` = 1 has no effect.
- Changes to `parity_mode` or `tx_data` mid-frame have no effect on that frame.

## Timing

- P = 1 if parity is enabled, else 0.
- Frame length: F = CLKS_PER_BIT × (1 + DATA_W + P + STOP_BITS) cycles.
- `tx_start` accepted at edge k:
  - `tx_busy`, `line_oe`, and `line_tx` = 0 (start bit) from edge k+1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - `line_oe` falls and `tx_done` = 1 at edge k+1+F.
  - `tx_busy` falls at edge k+1+F+TURNAROUND×CLKS_PER_BIT.
- Receive latency:
  - `rxs` lags `line_rx` by 2 cycles.
  - Each bit is sampled at its midpoint, ±1 cycle.
  - `rx_valid` comes 1 cycle after the stop-bit sample.
- `tx_busy` rises 1 cycle after RX_START entry, and stays high through RX and GUARD.

## Test plan

1. **Basic transmit.** DATA_W=8, CLKS_PER_BIT=16, no parity; `tx_start` with 0xC3.
   - `line_tx` bits: 0,1,1,0,0,0,0,1,1,1, each 16 cycles.
   - `tx_done` pulses 161 cycles after accept.
   - `tx_busy` falls 32 cycles after that.
2. **Transmit with parity.** 0xC1 with even parity gives parity bit 1; with odd parity it gives 0. The frame is 176 cycles.
3. **Receive loopback and parity error.**
   - Drive 0x5A on `line_rx` with correct odd parity: `rx_valid` pulses once, `rx_data` = 0x5A, both error flags 0.
   - Repeat with the parity bit flipped: `rx_parity_err` = 1 and `rx_data` = 0x5A.
4. **Frame error and false start.**
   - Stop bit driven 0: `rx_frame_err` = 1 and `rx_valid` still pulses.
   - A 4-cycle low glitch on `line_rx`: no `rx_valid` and `tx_busy` returns to 0.
5. **Collision and guard.**
   - `tx_start` in the same cycle as an `rxs` falling edge: receive completes and `line_oe` never rises.
   - `tx_start` during GUARD is ignored.
   - `line_rx` toggling during GUARD produces no `rx_valid`.
6. **Reset mid-frame.** Assert `rst` = 0 during TX_DATA: `line_tx` = 1 and `line_oe` = 0 immediately (asynchronously), with no `tx_done`. After release, a new `tx_start` is accepted normally.
